// File: rtl/roi_paste_axis.sv
// roi_paste_axis: places a raster ROI pixel stream into a full
// WIDTH x HEIGHT frame, filling the rest with a background value.
module roi_paste_axis #(
  parameter int WIDTH      = 800,
  parameter int HEIGHT     = 600,
  parameter int BIT_DATA_O = 8,
  parameter int BIT_COORD  = 32
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  start_i,
  input  logic [BIT_COORD-1:0]  xy_0_i,
  input  logic [BIT_COORD-1:0]  xy_1_i,
  input  logic [BIT_DATA_O-1:0] bg_i,
  input  logic [BIT_DATA_O-1:0] s_tdata_i,
  input  logic                  s_tvalid_i,
  input  logic                  s_tlast_i,
  output logic                  s_tready_o,
  output logic [BIT_DATA_O-1:0] m_tdata_o,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i,
  output logic                  m_tlast_o,
  output logic                  m_tuser_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  err_o
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [10:0]   XMAX = 11'(WIDTH - 1);
  localparam logic [9:0]    YMAX = 10'(HEIGHT - 1);
  localparam logic [XW-1:0] XEND = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YEND = YW'(HEIGHT - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_n;

  logic [10:0]           left, right;
  logic [9:0]            top, bottom;
  logic [BIT_DATA_O-1:0] bg;
  logic                  roi_ok;
  logic                  done_ld;
  logic                  err;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [BIT_DATA_O-1:0] m_data;
  logic                  m_valid, m_last, m_user;

  logic [10:0] x0, x1, xe;
  logic [9:0]  y0, y1, ye;
  logic        run, out_free, in_roi, at_end;
  logic        frame_end, load, s_hs, out_last_hs;
  logic        unused_coord;

  assign x0 = xy_0_i[26:16];
  assign x1 = xy_1_i[26:16];
  assign y0 = xy_0_i[9:0];
  assign y1 = xy_1_i[9:0];
  assign unused_coord = ^{xy_0_i[BIT_COORD-1:27], xy_0_i[15:10],
                          xy_1_i[BIT_COORD-1:27], xy_1_i[15:10]};

  assign xe = 11'(x);
  assign ye = 10'(y);

  assign run      = (state == RUN);
  assign out_free = !m_valid || m_tready_i;
  assign in_roi   = roi_ok &&
                    (xe >= left) && (xe <= right) &&
                    (ye >= top)  && (ye <= bottom);
  assign at_end    = (xe == right) && (ye == bottom);
  assign frame_end = (x == XEND) && (y == YEND);

  // done_ld blocks acceptance once the last beat is loaded,
  // since the counters have already wrapped back into the frame.
  assign s_tready_o = run && in_roi && out_free && !done_ld;
  assign load = run && out_free && !done_ld &&
                (!in_roi || s_tvalid_i);
  assign s_hs = s_tvalid_i && s_tready_o;
  assign out_last_hs = m_valid && m_tready_i && m_last;

  assign m_tdata_o    = m_data;
  assign m_tvalid_o   = m_valid;
  assign m_tlast_o    = m_last;
  assign m_tuser_o    = m_user;
  assign busy_o       = run;
  assign frame_done_o = out_last_hs;
  assign err_o        = err;

  // state register
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state <= IDLE;
    else        state <= state_n;
  end

  // next state: one frame per start, ends on last output handshake
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_i) state_n = RUN;
      RUN:     if (out_last_hs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // frame setup, raster counters and the tlast check
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      left    <= '0;
      right   <= '0;
      top     <= '0;
      bottom  <= '0;
      bg      <= '0;
      roi_ok  <= 1'b0;
      done_ld <= 1'b0;
      err     <= 1'b0;
      x       <= '0;
      y       <= '0;
    end else begin
      if (state == IDLE && start_i) begin
        left    <= (x0 < x1) ? x0 : x1;
        right   <= (x0 < x1) ? x1 : x0;
        top     <= (y0 < y1) ? y0 : y1;
        bottom  <= (y0 < y1) ? y1 : y0;
        bg      <= bg_i;
        roi_ok  <= (x0 <= XMAX) && (x1 <= XMAX) &&
                   (y0 <= YMAX) && (y1 <= YMAX);
        done_ld <= 1'b0;
        err     <= 1'b0;
        x       <= '0;
        y       <= '0;
      end
      if (load) begin
        if (x == XEND) begin
          x <= '0;
          y <= (y == YEND) ? '0 : y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
        if (frame_end) done_ld <= 1'b1;
      end
      if (s_hs && (s_tlast_i != at_end)) err <= 1'b1;
    end
  end

  // output register: loads a beat or drains when accepted
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_user  <= 1'b0;
    end else if (load) begin
      m_data  <= in_roi ? s_tdata_i : bg;
      m_user  <= (x == '0) && (y == '0);
      m_last  <= frame_end;
      m_valid <= 1'b1;
    end else if (m_tready_i) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_roi_paste_axis.sv
// tb_roi_paste_axis: directed frames checked against a
// scoreboard of expected output beats (WIDTH=8, HEIGHT=6).
module tb_roi_paste_axis;

  localparam int W = 8;
  localparam int H = 6;

  logic        clk = 1'b0;
  logic        arst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] xy_0_i = '0;
  logic [31:0] xy_1_i = '0;
  logic [7:0]  bg_i = '0;
  logic [7:0]  s_tdata_i = '0;
  logic        s_tvalid_i = 1'b0;
  logic        s_tlast_i = 1'b0;
  logic        s_tready_o;
  logic [7:0]  m_tdata_o;
  logic        m_tvalid_o;
  logic        m_tready_i = 1'b1;
  logic        m_tlast_o;
  logic        m_tuser_o;
  logic        busy_o;
  logic        frame_done_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;
  bit sready_seen = 0;

  logic [10:0] expq[$];
  logic [7:0]  src[$];
  bit          srcl[$];

  always #5 clk = ~clk;

  roi_paste_axis #(
    .WIDTH(W), .HEIGHT(H), .BIT_DATA_O(8), .BIT_COORD(32)
  ) dut (
    .clk_i(clk), .arst_i(arst_i), .start_i(start_i),
    .xy_0_i(xy_0_i), .xy_1_i(xy_1_i), .bg_i(bg_i),
    .s_tdata_i(s_tdata_i), .s_tvalid_i(s_tvalid_i),
    .s_tlast_i(s_tlast_i), .s_tready_o(s_tready_o),
    .m_tdata_o(m_tdata_o), .m_tvalid_o(m_tvalid_o),
    .m_tready_i(m_tready_i), .m_tlast_o(m_tlast_o),
    .m_tuser_o(m_tuser_o), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] xy(input int x, input int y);
    return {5'b0, 11'(x), 6'b0, 10'(y)};
  endfunction

  task automatic load_src(input int n, input int lastpos);
    src.delete();
    srcl.delete();
    for (int i = 0; i < n; i++) begin
      src.push_back(8'(i + 1));
      srcl.push_back((i + 1) == lastpos);
    end
  endtask

  // reference frame: {err, last, user, data} per beat
  task automatic build(input int x0, input int y0, input int x1,
                       input int y1, input logic [7:0] bg);
    int l, r, t, b, k;
    bit ok, e, in;
    logic [7:0] d;
    l = (x0 < x1) ? x0 : x1;
    r = (x0 < x1) ? x1 : x0;
    t = (y0 < y1) ? y0 : y1;
    b = (y0 < y1) ? y1 : y0;
    ok = (x0 < W) && (x1 < W) && (y0 < H) && (y1 < H);
    k = 0;
    e = 0;
    expq.delete();
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        in = ok && x >= l && x <= r && y >= t && y <= b;
        d = bg;
        if (in) begin
          d = src[k];
          if (srcl[k] != (x == r && y == b)) e = 1;
          k++;
        end
        expq.push_back({e, (x == W-1 && y == H-1),
                        (x == 0 && y == 0), d});
      end
    end
  endtask

  // called at posedge+1; returns at posedge+1 after the start edge
  task automatic start_frame(input int x0, input int y0, input int x1,
                             input int y1, input logic [7:0] bg);
    xy_0_i = xy(x0, y0);
    xy_1_i = xy(x1, y1);
    bg_i = bg;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    xy_0_i = xy(1, 1);
    xy_1_i = xy(1, 1);
    bg_i = 8'h55;
    chk("busy_after_start", busy_o, 1);
    chk("err_cleared", err_o, 0);
  endtask

  task automatic run_frame(input bit rnd, input int stop_after,
                           output int beats);
    int idx = 0;
    int cyc = 0;
    bit took = 0;
    bit fin = 0;
    bit stalled = 0;
    logic [9:0] held = '0;
    logic [10:0] e;
    beats = 0;
    while (!fin && cyc < 3000) begin
      if (cyc == 3) begin
        start_i = 1'b1;
        xy_0_i = xy(0, 0);
        xy_1_i = xy(7, 5);
      end else begin
        start_i = 1'b0;
      end
      if (idx >= src.size()) s_tvalid_i = 1'b0;
      else if (!s_tvalid_i || took)
        s_tvalid_i = !rnd || ($urandom_range(0, 2) != 0);
      if (idx < src.size()) begin
        s_tdata_i = src[idx];
        s_tlast_i = srcl[idx];
      end
      m_tready_i = !rnd || ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (s_tready_o) sready_seen = 1;
      took = s_tvalid_i && s_tready_o;
      if (took) idx++;
      if (stalled)
        chk("stall_hold", {m_tlast_o, m_tuser_o, m_tdata_o}, held);
      stalled = m_tvalid_o && !m_tready_i;
      held = {m_tlast_o, m_tuser_o, m_tdata_o};
      if (m_tvalid_o && m_tready_i) begin
        beats++;
        if (expq.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("beat", {err_o, m_tlast_o, m_tuser_o, m_tdata_o}, e);
          chk("done_on_last", frame_done_o, e[9]);
        end
        if (m_tlast_o) fin = 1;
        if (stop_after != 0 && beats == stop_after) fin = 1;
      end else if (frame_done_o) begin
        chk("done_spurious", 1, 0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!fin) chk("timeout", 0, 1);
    start_i = 1'b0;
    s_tvalid_i = 1'b0;
    s_tlast_i = 1'b0;
    m_tready_i = 1'b1;
  endtask

  task automatic frame(input int x0, input int y0, input int x1,
                       input int y1, input logic [7:0] bg,
                       input bit rnd);
    int beats;
    build(x0, y0, x1, y1, bg);
    start_frame(x0, y0, x1, y1, bg);
    run_frame(rnd, 0, beats);
    chk("beat_count", beats, 48);
    chk("queue_empty", expq.size(), 0);
    chk("busy_after_frame", busy_o, 0);
    chk("valid_after_frame", m_tvalid_o, 0);
  endtask

  initial begin
    int beats;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs_held",
        {m_tvalid_o, m_tdata_o, m_tlast_o, m_tuser_o,
         busy_o, frame_done_o, err_o, s_tready_o}, 0);
    arst_i = 1'b0;
    @(negedge clk);
    chk("reset_outputs",
        {m_tvalid_o, m_tdata_o, m_tlast_o, m_tuser_o,
         busy_o, frame_done_o, err_o, s_tready_o}, 0);
    @(posedge clk); #1;

    load_src(9, 9);
    frame(2, 1, 4, 3, 8'hAA, 0);
    chk("err_basic", err_o, 0);

    load_src(9, 9);
    frame(4, 3, 2, 1, 8'hAA, 0);
    chk("err_swapped", err_o, 0);

    load_src(9, 9);
    frame(2, 1, 4, 3, 8'hAA, 1);
    chk("err_random", err_o, 0);

    load_src(9, 5);
    frame(2, 1, 4, 3, 8'hAA, 1);
    chk("err_early_last", err_o, 1);

    sready_seen = 0;
    load_src(9, 9);
    frame(2, 1, 8, 3, 8'hAA, 0);
    chk("invalid_no_ready", sready_seen, 0);
    chk("err_invalid", err_o, 0);

    load_src(9, 9);
    build(2, 1, 4, 3, 8'hAA);
    start_frame(2, 1, 4, 3, 8'hAA);
    run_frame(0, 20, beats);
    chk("beats_before_reset", beats, 20);
    arst_i = 1'b1;
    #1;
    chk("midframe_reset",
        {m_tvalid_o, m_tdata_o, m_tlast_o, m_tuser_o,
         busy_o, frame_done_o, err_o, s_tready_o}, 0);
    expq.delete();
    @(posedge clk); #1;
    arst_i = 1'b0;
    @(posedge clk); #1;

    load_src(1, 1);
    frame(0, 0, 0, 0, 8'h11, 1);
    chk("err_single", err_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
